uart_rx: RTL
============

# uart_rx

Serial receiver that consumes the single-wire line driven by the `uart_tx` transmitter stage and recovers 8N1 bytes (start bit low, 8 data bits LSB first, stop bit high). The `rx` input is asynchronous to `clk`: it is synchronised, the start edge is qualified at mid-bit, and each bit is sampled at its centre. Received bytes are held in a valid/ack output register for the processor-side consumer, with framing-error and overrun status. At the default `CLKS_PER_BIT=1` it accepts back-to-back frames from `uart_tx`, which produces one frame every 10 cycles.

## Interface
- `CLKS_PER_BIT`, default 1: clock cycles per bit, ≥1. `HALF = CLKS_PER_BIT/2`, integer division.
- `clk  in  1`: single clock.
- `rst  in  1`: reset, asynchronous, active-low.
- `rx  in  1`: serial line, idle high, asynchronous.
- `ack  in  1`: consumer acknowledge, one-cycle pulse.
- `rx_data  out  8`: last good byte.
- `rx_valid  out  1`: `rx_data` holds an unacknowledged byte.
- `frame_err  out  1`: sticky; a stop bit was sampled low.
- `overrun  out  1`: sticky; a good frame was dropped because `rx_valid` was still set.

## Operation
- **Synchroniser.** `rx` passes through 2 flops, both reset to 1, giving `rx_s`. All logic uses `rx_s` only.
- **Counters.** `clk_cnt` is at least 1 bit wide and sized for `CLKS_PER_BIT-1`. `bit_idx` is 3 bits. `shift` is 8 bits, filled LSB first.
- **States:** IDLE, START, DATA, STOP, BREAK.
- **IDLE.**
  - On `rx_s==0`, the cycle is start-detect cycle t.
  - If `HALF==0`: go to DATA with `clk_cnt=0`, `bit_idx=0`.
  - Otherwise: go to START with `clk_cnt=1`.
- **START.**
  - While `clk_cnt != HALF`, increment `clk_cnt`.
  - At `clk_cnt == HALF` (cycle t+HALF), sample the start bit:
    - `rx_s==0`: go to DATA, `clk_cnt=0`, `bit_idx=0`.
    - `rx_s==1`: glitch; return to IDLE with no status change.
- **DATA.**
  - When `clk_cnt == CLKS_PER_BIT-1`: `shift[bit_idx] <= rx_s`, `clk_cnt <= 0`. If `bit_idx==7`, go to STOP; otherwise increment `bit_idx`.
  - Otherwise increment `clk_cnt`.
- **STOP.** Sample at `clk_cnt == CLKS_PER_BIT-1`, which is cycle t+HALF+9·CLKS_PER_BIT.
  - `rx_s==1`, good frame, then go to IDLE:
    - If `rx_valid==0` or `ack==1`: `rx_data <= shift`, `rx_valid <= 1`.
    - Otherwise: `overrun <= 1`; `rx_data` is kept and the new byte is dropped.
  - `rx_s==0`: `frame_err <= 1`, byte discarded, go to BREAK.
- **BREAK.** Stay until `rx_s==1`, then go to IDLE. This prevents repeated errors while the line is held low.
- **ack.** Clears `rx_valid`, `frame_err` and `overrun` on the next edge.
  - A set in the same cycle wins over the clear. Exception: a good frame together with `ack` loads the new data, keeps `rx_valid=1`, and does not set `overrun`.
- **Reset (any time, including mid-frame):**
  - State goes to IDLE; the frame is aborted and no `rx_valid` is produced.
  - `rx_data=0`, `rx_valid=0`, `frame_err=0`, `overrun=0`, synchroniser = 1, counters = 0.

## Timing
- **Latency.** `rx_valid` rises 2 + HALF + 9·CLKS_PER_BIT + 1 cycles after the start bit first appears on `rx`. At `CLKS_PER_BIT=1` this is 12 cycles.
- **Back-to-back.** At `CLKS_PER_BIT=1` the STOP sample is at t+9 and the FSM is back in IDLE at t+10. That is exactly when the next start bit from `uart_tx` arrives, so there is no gap requirement.
- **Outputs.** All outputs are registered, with no combinational path from inputs. `ack` is required only while `rx_valid` or a flag is set; `ack` with nothing pending is ignored.
- **Bit sampling.** Each bit is sampled exactly once, at its centre.

## Structure
- **Package `uart_pkg`:** `DATA_BITS=8`, the state encoding typedef (IDLE/START/DATA/STOP/BREAK), and idle-line level `LINE_IDLE=1'b1`.
- **Sub-module `uart_sync`:** 2-flop synchroniser with async active-low reset to `LINE_IDLE`. The rest of the design is a single FSM in `uart_rx`.

## Test plan
- **Single byte.** `CLKS_PER_BIT=1`, `uart_tx` instance drives `rx`, one `ready` pulse with 0xA5 -> `rx_data=0xA5`, `rx_valid=1` exactly 12 cycles after the start bit, flags 0. Then `ack` -> `rx_valid=0`.
- **Back-to-back.** `ready` held through 0x00 then 0xFF, `ack` one cycle after each `rx_valid` -> both bytes received in order, 10 cycles apart, `overrun=0`.
- **Overrun.** Send 0x3C then 0xC3 with no `ack` -> `rx_data` stays 0x3C, `overrun=1`. Then `ack` -> `rx_valid`, `overrun` and `frame_err` all 0.
- **Glitch rejection.** `CLKS_PER_BIT=16`, `rx` low for 4 cycles -> FSM returns to IDLE, no status change. Then a valid 0x81 frame -> `rx_data=0x81`.
- **Framing error and break.** Stop bit forced low, then line held low 40 cycles -> `frame_err=1` once, `rx_valid=0`, FSM stays in BREAK. Line released, then 0x5A frame -> `rx_data=0x5A`, `rx_valid=1`, `frame_err` still 1 until `ack`.
- **Reset mid-frame.** `rst` pulled low during bit 4 -> all outputs 0 immediately and no `rx_valid`. After release, a 0x96 frame -> received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and receiver state encoding for the uart blocks
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: 2-flop synchroniser for the asynchronous serial line
module uart_sync import uart_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {q, m} <= {LINE_IDLE, LINE_IDLE};
    else {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with mid-bit sampling and a valid/ack output register
module uart_rx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_C = CW'(HALF);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  state_t state;
  logic rx_s;
  logic [CW-1:0] clk_cnt;
  logic [2:0] bit_idx;
  logic [DATA_BITS-1:0] shift;
  uart_sync u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));
  // ack clears first; any set later in the same cycle overrides it
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ack) begin
        rx_valid  <= 1'b0;
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end
      case (state)
        IDLE:
          if (!rx_s) begin
            clk_cnt <= HALF == 0 ? '0 : CW'(1);
            bit_idx <= '0;
            state   <= HALF == 0 ? DATA : START;
          end
        START:
          if (clk_cnt != HALF_C) clk_cnt <= clk_cnt + 1'b1;
          else begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end
        DATA:
          if (clk_cnt == LAST) begin
            shift[bit_idx] <= rx_s;
            clk_cnt        <= '0;
            bit_idx        <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else clk_cnt <= clk_cnt + 1'b1;
        STOP:
          if (clk_cnt == LAST) begin
            clk_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              if (!rx_valid || ack) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else overrun <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else clk_cnt <= clk_cnt + 1'b1;
        BREAK:
          if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
